// File: rtl/quotient_multiplier.sv
// Iterative MSB-first shift-add multiplier: product = quotient * divisor + remainder.
// One quotient bit per clock; single operation in flight, valid/ready on both sides.
module quotient_multiplier #(
    parameter int unsigned M = 26,
    parameter int unsigned N = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-N-1:0] quotient,
    input  logic [N-1:0]   divisor,
    input  logic [N-1:0]   remainder,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   product,
    output logic           rem_err
);

    localparam int unsigned Q  = M - N;
    localparam int unsigned CW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [Q-1:0]    r_qreg;
    logic [N-1:0]    r_div;
    logic [N-1:0]    r_rem;
    logic [M-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic [M-1:0]    r_product;
    logic            r_rem_err;
    logic            w_last;
    logic [M-1:0]    w_acc_next;

    assign w_last = (r_cnt == '0);

    // Horner step; the remainder is folded in on the final step only.
    always_comb begin
        w_acc_next = {r_acc[M-2:0], 1'b0};
        if (r_qreg[Q-1]) begin
            w_acc_next = w_acc_next + {{Q{1'b0}}, r_div};
        end
        if (w_last) begin
            w_acc_next = w_acc_next + {{Q{1'b0}}, r_rem};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StBusy;
            StBusy:  if (w_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qreg    <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_rem_err <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_qreg    <= quotient;
                        r_div     <= divisor;
                        r_rem     <= remainder;
                        r_acc     <= '0;
                        r_cnt     <= CW'(Q - 1);
                        r_rem_err <= (remainder >= divisor);
                    end
                end
                StBusy: begin
                    r_acc  <= w_acc_next;
                    r_qreg <= {r_qreg[Q-2:0], 1'b0};
                    r_cnt  <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign rem_err = r_rem_err;

endmodule

// File: tb/tb_quotient_multiplier.sv
// Scoreboard bench for quotient_multiplier: driver pushes expected results at acceptance,
// monitor pops and compares on every output handshake.
module tb_quotient_multiplier;

    localparam int unsigned M = 26;
    localparam int unsigned N = 14;
    localparam int unsigned Q = M - N;

    typedef struct {
        logic [M-1:0] p;
        logic         e;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [Q-1:0] quotient;
    logic [N-1:0] divisor;
    logic [N-1:0] remainder;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] product;
    logic         rem_err;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   ready_mode;  // 0: low, 1: high, 2: random

    quotient_multiplier #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .rem_err   (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", longint'(product), longint'(e.p));
                    check("rem_err", longint'(rem_err), longint'(e.e));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send(input int q, input int d, input int r);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        quotient  = Q'(q);
        divisor   = N'(d);
        remainder = N'(r);
        for (int i = 0; i < 400 && !done; i++) begin
            if (in_ready) begin
                exp_t e;
                @(posedge clk);
                e.p = M'(longint'(q) * longint'(d) + longint'(r));
                e.e = (r >= d);
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int seen;
        total      = 0;
        bad        = 0;
        ready_mode = 1;
        rst        = 1'b1;
        in_valid   = 1'b0;
        quotient   = '0;
        divisor    = '0;
        remainder  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        check("reset_rem_err", rem_err, 0);
        @(posedge clk);
        #1;

        // Latency and single-cycle valid with out_ready held high.
        send(1000, 37, 5);
        wait_out(cyc);
        check("latency", cyc, 12);
        check("p_37005", product, 37005);
        @(posedge clk);
        #1;
        check("valid_one_cycle", out_valid, 0);
        check("in_ready_back", in_ready, 1);

        send(4095, 16383, 16382);
        send(4095, 16383, 16383);
        send(5, 0, 7);
        send(0, 100, 99);
        drain();

        // Backpressure with a second operand set pending.
        ready_mode = 0;
        send(3, 3, 1);
        wait_out(cyc);
        in_valid  = 1'b1;
        quotient  = 2;
        divisor   = 2;
        remainder = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_product", product, 10);
            check("bp_in_ready_low", in_ready, 0);
        end
        ready_mode = 1;
        send(2, 2, 0);
        drain();

        // Reset during the sixth BUSY cycle.
        send(100, 100, 0);
        void'(exp_q.pop_back());
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_product", product, 0);
        seen = 0;
        for (int i = 0; i < Q + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        send(7, 9, 2);
        drain();

        // Random sweep with random gaps on both sides.
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            int q;
            int d;
            int r;
            q = $urandom_range(0, 4095);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 16383);
            r = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16383)
                                            : ((d == 0) ? 0 : $urandom_range(0, d - 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(q, d, r);
        end
        ready_mode = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
